// File: rtl/router_pkg.sv
// router_pkg: shared types and defaults for the router input channel.
// Holds the channel FSM state enum, default widths and a counter-width helper.
package router_pkg;

   typedef enum logic [2:0] {
      SYNC,
      IDLE,
      ADDR,
      PAD,
      DATA,
      DROP
   } state_t;

   localparam int NUM_PORTS_DEF  = 16;
   localparam int DATA_W_DEF     = 8;
   localparam int PAD_CYCLES_DEF = 5;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/router_in_port_if.sv
// router_in_port_if: serial packet input plus buffered word output bundle.
// slave = the input channel, master = sender/consumer side.
interface router_in_port_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);

   logic              din;
   logic              valid_n;
   logic              frame_n;
   logic              busy_n;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_dest;
   logic              out_sop;
   logic              out_eop;
   logic              out_err;
   logic              drop;

   modport slave (
      input  din, valid_n, frame_n, out_ready,
      output busy_n, out_valid, out_data, out_dest,
      output out_sop, out_eop, out_err, drop
   );

   modport master (
      output din, valid_n, frame_n, out_ready,
      input  busy_n, out_valid, out_data, out_dest,
      input  out_sop, out_eop, out_err, drop
   );

endinterface

// File: rtl/router_sync_fifo.sv
// router_sync_fifo: first-word-fall-through FIFO, async active-high reset.
// Ports: wr_en/wr_data push, rd_en pop, rd_data head; full, empty, free_cnt.
module router_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   free_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             rd_ok;
   logic             wr_ok;

   // Extra pointer MSB separates full (MSBs differ) from empty.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign free_cnt = CAP - (wr_ptr - rd_ptr);
   assign rd_data  = mem[rd_ptr[AW-1:0]];

   // A push into a full buffer is taken when the head leaves that cycle.
   assign rd_ok = rd_en & ~empty;
   assign wr_ok = wr_en & (~full | rd_ok);

   always_ff @(posedge clock) begin
      if (wr_ok) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/router_in_port.sv
// router_in_port: serial-to-parallel router input channel with buffering.
// Ports: clock, reset (async, active-high); bus.slave carries din/valid_n/
//   frame_n in, busy_n back, out_* FWFT word stream and drop pulse.
module router_in_port
   import router_pkg::*;
#(
   parameter int NUM_PORTS   = NUM_PORTS_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int PAD_CYCLES  = PAD_CYCLES_DEF,
   parameter int FIFO_DEPTH  = 16,
   parameter int BUSY_THRESH = 2
) (
   input logic            clock,
   input logic            reset,
   router_in_port_if.slave bus
);

   localparam int ADDR_W = $clog2(NUM_PORTS);
   localparam int AC_W   = cnt_w(ADDR_W);
   localparam int PC_W   = cnt_w(PAD_CYCLES);
   localparam int BC_W   = cnt_w(DATA_W);
   localparam int FW     = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] data;
      logic              sop;
      logic              eop;
      logic              err;
   } entry_t;

   localparam int EW = $bits(entry_t);

   state_t            state;
   logic [ADDR_W-1:0] dest;
   logic [AC_W-1:0]   addr_cnt;
   logic [PC_W-1:0]   pad_cnt;
   logic [BC_W-1:0]   bit_cnt;
   logic [DATA_W-1:0] word;
   logic              first;
   logic              busy_q;
   logic              drop_q;

   logic              acc;
   logic              last_bit;
   logic              part;
   logic [DATA_W-1:0] word_nxt;
   logic              push;
   logic              p_eop;
   logic              p_err;
   logic              pop;
   logic              fail;
   logic              wr_ok;
   logic              full;
   logic              empty;
   logic [FW-1:0]     free_cnt;
   logic [FW-1:0]     free_nxt;
   entry_t            wr_entry;
   entry_t            rd_entry;
   logic [EW-1:0]     rd_raw;

   assign acc      = (state == DATA) && !bus.valid_n;
   assign last_bit = (bit_cnt == BC_W'(DATA_W-1));
   assign part     = (bit_cnt != '0);
   assign word_nxt = acc ? (word | (DATA_W'(bus.din) << bit_cnt)) : word;

   // A word leaves on its last bit, or early (err) when the frame ends.
   always_comb begin
      push  = 1'b0;
      p_eop = 1'b0;
      p_err = 1'b0;
      if (state == DATA) begin
         if (acc && last_bit) begin
            push  = 1'b1;
            p_eop = bus.frame_n;
         end else if (bus.frame_n && (acc || part)) begin
            push  = 1'b1;
            p_eop = 1'b1;
            p_err = 1'b1;
         end
      end
   end

   always_comb begin
      wr_entry      = '0;
      wr_entry.dest = dest;
      wr_entry.data = word_nxt;
      wr_entry.sop  = first;
      wr_entry.eop  = p_eop;
      wr_entry.err  = p_err;
   end

   assign pop      = bus.out_ready & ~empty;
   assign fail     = push & full & ~pop;
   assign wr_ok    = push & (~full | pop);
   assign free_nxt = free_cnt - FW'(wr_ok) + FW'(pop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= SYNC;
         dest     <= '0;
         addr_cnt <= '0;
         pad_cnt  <= '0;
         bit_cnt  <= '0;
         word     <= '0;
         first    <= 1'b0;
         busy_q   <= 1'b1;
         drop_q   <= 1'b0;
      end else begin
         drop_q <= 1'b0;
         busy_q <= (free_nxt > FW'(BUSY_THRESH));
         unique case (state)
            // Skip any packet already in flight when reset released.
            SYNC: begin
               if (bus.frame_n) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (!bus.frame_n) begin
                  dest     <= ADDR_W'(bus.din);
                  addr_cnt <= AC_W'(1);
                  pad_cnt  <= '0;
                  state    <= (ADDR_W == 1) ? PAD : ADDR;
               end
            end
            ADDR: begin
               if (bus.frame_n) begin
                  drop_q <= 1'b1;
                  state  <= IDLE;
               end else begin
                  dest[addr_cnt] <= bus.din;
                  if (addr_cnt == AC_W'(ADDR_W-1)) begin
                     state <= PAD;
                  end else begin
                     addr_cnt <= addr_cnt + 1'b1;
                  end
               end
            end
            PAD: begin
               if (bus.frame_n) begin
                  drop_q <= 1'b1;
                  state  <= IDLE;
               end else if (pad_cnt == PC_W'(PAD_CYCLES-1)) begin
                  bit_cnt <= '0;
                  word    <= '0;
                  first   <= 1'b1;
                  state   <= DATA;
               end else begin
                  pad_cnt <= pad_cnt + 1'b1;
               end
            end
            DATA: begin
               if (fail) begin
                  drop_q <= bus.frame_n;
                  state  <= bus.frame_n ? IDLE : DROP;
               end else if (push) begin
                  first   <= 1'b0;
                  word    <= '0;
                  bit_cnt <= '0;
                  if (bus.frame_n) begin
                     state <= IDLE;
                  end
               end else if (bus.frame_n) begin
                  // Stall-cycle end with nothing pending; empty if no word yet.
                  drop_q <= first;
                  state  <= IDLE;
               end else if (acc) begin
                  word    <= word_nxt;
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            DROP: begin
               if (bus.frame_n) begin
                  drop_q <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= SYNC;
         endcase
      end
   end

   router_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (push),
      .wr_data  (wr_entry),
      .rd_en    (pop),
      .rd_data  (rd_raw),
      .full     (full),
      .empty    (empty),
      .free_cnt (free_cnt)
   );

   // Head fields read as zero while the buffer is empty.
   assign rd_entry      = empty ? '0 : entry_t'(rd_raw);
   assign bus.out_valid = ~empty;
   assign bus.out_data  = rd_entry.data;
   assign bus.out_dest  = rd_entry.dest;
   assign bus.out_sop   = rd_entry.sop;
   assign bus.out_eop   = rd_entry.eop;
   assign bus.out_err   = rd_entry.err;
   assign bus.busy_n    = busy_q;
   assign bus.drop      = drop_q;

endmodule
